// File: rtl/wf_instr_queue_bank_pkg.sv
// Shared wavepool constants and head-bus helpers. The head-select mux uses the
// same slice helpers so both sides agree on where head[i] lives in the flat bus.
package wf_instr_queue_bank_pkg;

    localparam int NUM_WF  = 40;
    localparam int ENTRY_W = 35;
    localparam int WFID_W  = 6;
    localparam int DEPTH   = 4;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int HEAD_W  = NUM_WF * ENTRY_W;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef logic [WFID_W-1:0]  wfid_t;

    // Bit offset of head[i] inside the flat head bus.
    function automatic int unsigned head_lsb(input int unsigned i);
        return i * ENTRY_W;
    endfunction

    // Extract head[i] from the flat head bus.
    function automatic entry_t head_of(input logic [HEAD_W-1:0] bus, input int unsigned i);
        return bus[head_lsb(i) +: ENTRY_W];
    endfunction

endpackage

// File: rtl/wf_instr_queue_bank_if.sv
// Fetch/issue/flush request bus and queue status bus of the instruction queue bank.
interface wf_instr_queue_bank_if;
    import wf_instr_queue_bank_pkg::*;

    logic                  wr_en;
    wfid_t                 wr_wfid;
    entry_t                wr_data;
    logic                  rd_en;
    wfid_t                 rd_wfid;
    logic                  flush_en;
    wfid_t                 flush_wfid;
    logic [HEAD_W-1:0]     head_data;
    logic [NUM_WF-1:0]     head_valid;
    logic [NUM_WF-1:0]     wf_full;
    logic                  wr_overflow;
    logic                  rd_underflow;

    // Requester side: fetch, issue and the flush source.
    modport master (
        output wr_en, wr_wfid, wr_data, rd_en, rd_wfid, flush_en, flush_wfid,
        input  head_data, head_valid, wf_full, wr_overflow, rd_underflow
    );

    // Queue bank side.
    modport slave (
        input  wr_en, wr_wfid, wr_data, rd_en, rd_wfid, flush_en, flush_wfid,
        output head_data, head_valid, wf_full, wr_overflow, rd_underflow
    );

endinterface

// File: rtl/wf_queue_slot.sv
// One per-wavefront FIFO. Flush wins over push/pop; a push into a full queue
// is accepted only when a pop drains the same queue in the same cycle.
module wf_queue_slot
    import wf_instr_queue_bank_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t push_data,
    output entry_t head,
    output logic   valid,
    output logic   full,
    output logic   overflow,
    output logic   underflow
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head      = mem[rd_ptr];

    assign do_pop    = pop  & ~flush & valid;
    assign do_push   = push & ~flush & (~full | pop);
    assign overflow  = push & ~flush & full & ~pop;
    assign underflow = pop  & ~flush & ~valid;

    // Pointer and occupancy update; flush clears this queue only.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so no stale data survives it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this memory is reset deliberately (head_data must read 0 after reset), which keeps it in flops.
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wf_instr_queue_bank.sv
// Bank of NUM_WF instruction queues. Decodes wavefront ids into one-hot
// push/pop/flush strobes and registers the ORed error conditions as pulses.
module wf_instr_queue_bank
    import wf_instr_queue_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wf_instr_queue_bank_if.slave bus
);

    logic [NUM_WF-1:0] push_vec;
    logic [NUM_WF-1:0] pop_vec;
    logic [NUM_WF-1:0] flush_vec;
    logic [NUM_WF-1:0] ovf_vec;
    logic [NUM_WF-1:0] unf_vec;
    logic [NUM_WF-1:0] valid_vec;
    logic [NUM_WF-1:0] full_vec;
    logic [HEAD_W-1:0] head_bus;
    logic              ovf_q;
    logic              unf_q;

    // Ids at or above NUM_WF match no slot, so such requests fall away silently.
    for (genvar g = 0; g < NUM_WF; g++) begin : g_slot
        assign push_vec[g]  = bus.wr_en    && (bus.wr_wfid    == WFID_W'(g));
        assign pop_vec[g]   = bus.rd_en    && (bus.rd_wfid    == WFID_W'(g));
        assign flush_vec[g] = bus.flush_en && (bus.flush_wfid == WFID_W'(g));

        wf_queue_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[g]),
            .pop       (pop_vec[g]),
            .flush     (flush_vec[g]),
            .push_data (bus.wr_data),
            .head      (head_bus[g*ENTRY_W +: ENTRY_W]),
            .valid     (valid_vec[g]),
            .full      (full_vec[g]),
            .overflow  (ovf_vec[g]),
            .underflow (unf_vec[g])
        );
    end

    // Error pulses: one cycle after the offending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= |ovf_vec;
            unf_q <= |unf_vec;
        end
    end

    assign bus.head_data    = head_bus;
    assign bus.head_valid   = valid_vec;
    assign bus.wf_full      = full_vec;
    assign bus.wr_overflow  = ovf_q;
    assign bus.rd_underflow = unf_q;

endmodule
